// File: rtl/sdram_sched_if.sv
// Command word types and the bundled FIFO / requester port of the SDRAM command scheduler.
package sdram_sched_pkg;
    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_MRS   = 3'd1,
        CMD_REF   = 3'd2,
        CMD_PALL  = 3'd3,
        CMD_ACT   = 3'd4,
        CMD_PRE   = 3'd5,
        CMD_WRITE = 3'd6,
        CMD_READ  = 3'd7
    } cmd_t;

    typedef struct packed {
        logic [8:0]  column;
        logic [15:0] data;
    } cmd_data_t;

    typedef struct packed {
        cmd_t       cmd;
        logic [1:0] ba;
        cmd_data_t  d;
    } data_t;
endpackage

interface sdram_sched_if;
    import sdram_sched_pkg::*;

    logic        full;
    logic        fifo_wrreq;
    data_t       fifo_in;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [1:0]  rd_id;
    logic        rd_ack;

    modport master (
        input  full,
        output fifo_wrreq, fifo_in,
        input  wr_req, wr_addr, wr_data,
        output wr_ack,
        input  rd_req, rd_addr, rd_id,
        output rd_ack
    );

    modport slave (
        output full,
        input  fifo_wrreq, fifo_in,
        output wr_req, wr_addr, wr_data,
        input  wr_ack,
        output rd_req, rd_addr, rd_id,
        input  rd_ack
    );
endinterface

// File: rtl/sdram_sched.sv
// SDRAM command scheduler: power-up sequence, refresh insertion and close-page
// arbitration between one writer and one burst reader, feeding the command FIFO.
module sdram_sched
    import sdram_sched_pkg::*;
#(
    parameter int INIT_REFS  = 8,
    parameter int MAX_WBATCH = 8
) (
    input  logic            clkSDRAM,
    input  logic            n_reset,
    input  logic            icnt_ovf,
    output logic            init_done,
    sdram_sched_if.master   bus
);

    localparam int BW = $clog2(MAX_WBATCH + 1);

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PALL,
        S_INIT_REF,
        S_INIT_MRS,
        S_IDLE,
        S_REF,
        S_ACT,
        S_WR,
        S_RD,
        S_PRE
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    ref_cnt;
    logic [BW-1:0] batch;
    logic          ref_pend;
    logic          last_grant_rd;
    logic [1:0]    lat_ba;
    logic [12:0]   lat_row;

    logic          pending;
    logic          push;
    data_t         cmd_word;
    logic          wr_row_hit;
    logic          wr_ok;
    logic          grant;
    logic          grant_rd;
    logic [23:0]   grant_addr;

    assign wr_row_hit = (bus.wr_addr[23:9] == {lat_ba, lat_row});
    assign wr_ok      = bus.wr_req && wr_row_hit && (batch < BW'(MAX_WBATCH)) && !ref_pend;

    // Refresh always wins in IDLE; contention alternates, otherwise the lone requester wins.
    assign grant      = (state == S_IDLE) && !ref_pend && (bus.wr_req || bus.rd_req);
    assign grant_rd   = (bus.wr_req && bus.rd_req) ? !last_grant_rd : bus.rd_req;
    assign grant_addr = grant_rd ? bus.rd_addr : bus.wr_addr;

    assign push           = pending && !bus.full;
    assign bus.fifo_wrreq = push;
    assign bus.fifo_in    = cmd_word;
    assign bus.wr_ack     = push && (state == S_WR);
    assign bus.rd_ack     = push && (state == S_RD);

    always_comb begin
        state_nxt = state;
        pending   = 1'b0;
        cmd_word  = '0;
        case (state)
            S_INIT_WAIT: begin
                if (icnt_ovf) state_nxt = S_INIT_PALL;
            end
            S_INIT_PALL: begin
                pending      = 1'b1;
                cmd_word.cmd = CMD_PALL;
                if (!bus.full) state_nxt = S_INIT_REF;
            end
            S_INIT_REF: begin
                pending      = 1'b1;
                cmd_word.cmd = CMD_REF;
                if (!bus.full && ref_cnt == 4'(INIT_REFS - 1)) state_nxt = S_INIT_MRS;
            end
            S_INIT_MRS: begin
                pending      = 1'b1;
                cmd_word.cmd = CMD_MRS;
                if (!bus.full) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (ref_pend)   state_nxt = S_REF;
                else if (grant) state_nxt = S_ACT;
            end
            S_REF: begin
                pending      = 1'b1;
                cmd_word.cmd = CMD_REF;
                if (!bus.full) state_nxt = S_IDLE;
            end
            S_ACT: begin
                pending           = 1'b1;
                cmd_word.cmd      = CMD_ACT;
                cmd_word.ba       = lat_ba;
                cmd_word.d.data   = {3'b000, lat_row};
                if (!bus.full) state_nxt = last_grant_rd ? S_RD : S_WR;
            end
            S_WR: begin
                // A failed qualification closes the row without consuming a FIFO slot.
                if (wr_ok) begin
                    pending           = 1'b1;
                    cmd_word.cmd      = CMD_WRITE;
                    cmd_word.ba       = lat_ba;
                    cmd_word.d.column = bus.wr_addr[8:0];
                    cmd_word.d.data   = bus.wr_data;
                end else begin
                    state_nxt = S_PRE;
                end
            end
            S_RD: begin
                pending           = 1'b1;
                cmd_word.cmd      = CMD_READ;
                cmd_word.ba       = lat_ba;
                cmd_word.d.column = bus.rd_addr[8:0];
                cmd_word.d.data   = {14'd0, bus.rd_id};
                if (!bus.full) state_nxt = S_PRE;
            end
            S_PRE: begin
                pending      = 1'b1;
                cmd_word.cmd = CMD_PRE;
                cmd_word.ba  = lat_ba;
                if (!bus.full) state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT_WAIT;
        endcase
    end

    always_ff @(posedge clkSDRAM or negedge n_reset) begin
        if (!n_reset) begin
            state         <= S_INIT_WAIT;
            ref_cnt       <= '0;
            batch         <= '0;
            ref_pend      <= 1'b0;
            last_grant_rd <= 1'b1;
            init_done     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == S_INIT_PALL)
                ref_cnt <= '0;
            else if (state == S_INIT_REF && push)
                ref_cnt <= ref_cnt + 4'd1;

            if (state == S_ACT)
                batch <= '0;
            else if (state == S_WR && push)
                batch <= batch + BW'(1);

            // A tick landing on the REF push re-arms the request; otherwise ticks saturate.
            if (state == S_REF && push)
                ref_pend <= icnt_ovf;
            else if (icnt_ovf && init_done)
                ref_pend <= 1'b1;

            if (state == S_INIT_MRS && push)
                init_done <= 1'b1;

            if (grant)
                last_grant_rd <= grant_rd;
        end
    end

    always_ff @(posedge clkSDRAM) begin
        if (grant) begin
            lat_ba  <= grant_addr[23:22];
            lat_row <= grant_addr[21:9];
        end
    end

endmodule
